// File: rtl/sprite_tex_loader_pkg.sv
// Constants shared by the sprite texture loader and the renderer texture RAMs.
// Segment lengths, RAM depths, port address widths and the loader state encoding.
package sprite_tex_loader_pkg;

    localparam int BIRD_SEG_WORDS = 5250;
    localparam int PIPE_SEG_WORDS = 40000;
    localparam int BASE_SEG_WORDS = 9600;

    // Renderer RAM depths; the pipe RAM keeps only the first 4000 words it is sent.
    localparam int BIRD_RAM_DEPTH = 5250;
    localparam int PIPE_RAM_DEPTH = 4000;
    localparam int BASE_RAM_DEPTH = 9600;

    localparam int BIRD_AW = 13;
    localparam int PIPE_AW = 16;
    localparam int BASE_AW = 14;
    localparam int CNT_W   = 16;
    localparam int DATA_W  = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BIRD = 3'd1;
    localparam logic [2:0] ST_PIPE = 3'd2;
    localparam logic [2:0] ST_BASE = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        BIRD = ST_BIRD,
        PIPE = ST_PIPE,
        BASE = ST_BASE,
        DONE = ST_DONE
    } load_state_e;

    function automatic logic [CNT_W-1:0] seg_term(input int words);
        return CNT_W'(words - 1);
    endfunction

endpackage

// File: rtl/sprite_tex_loader_seg_counter.sv
// Word counter for one texture segment: clear, increment, and a flag that is
// high while the count sits on the segment's terminal value.
module tex_seg_counter
    import sprite_tex_loader_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign last = (cnt == term);

endmodule

// File: rtl/sprite_tex_loader.sv
// Copies the SDRAM texture stream into the bird, pipe and ground-base RAMs of
// the sprite renderer, one registered write strobe per accepted source word.
//
// state | meaning
// IDLE  | waiting for start; source not accepted
// BIRD  | forwarding words to the bird RAM
// PIPE  | forwarding words to the pipe RAM
// BASE  | forwarding words to the ground-base RAM
// DONE  | last base word taken; done/loaded follow on the next edge
module sprite_tex_loader
    import sprite_tex_loader_pkg::*;
#(
    parameter int BIRD_WORDS = BIRD_SEG_WORDS,
    parameter int PIPE_WORDS = PIPE_SEG_WORDS,
    parameter int BASE_WORDS = BASE_SEG_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               src_valid,
    input  logic [DATA_W-1:0]  src_data,
    output logic               src_ready,
    output logic [DATA_W-1:0]  load_data,
    output logic               bird_load_en,
    output logic [BIRD_AW-1:0] bird_load_addr,
    output logic               pipe_load_en,
    output logic [PIPE_AW-1:0] pipe_load_addr,
    output logic               base_load_en,
    output logic [BASE_AW-1:0] base_load_addr,
    output logic               busy,
    output logic               done,
    output logic               loaded
);

    load_state_e      state;
    load_state_e      state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_cnt;
    logic             seg_last;
    logic             accept;
    logic             start_ok;
    logic             cnt_clr;
    logic             bird_wr;
    logic             pipe_wr;
    logic             base_wr;
    logic             done_nx;

    // Ready depends on state only so the FIFO side never sees a valid->ready path.
    assign src_ready = (state == BIRD) || (state == PIPE) || (state == BASE);
    assign busy      = src_ready;
    assign accept    = src_valid && src_ready;
    assign start_ok  = start && !abort && (state == IDLE);
    assign cnt_clr   = abort || start_ok || (accept && seg_last);

    always_comb begin
        term_cnt = '0;
        case (state)
            BIRD:    term_cnt = seg_term(BIRD_WORDS);
            PIPE:    term_cnt = seg_term(PIPE_WORDS);
            BASE:    term_cnt = seg_term(BASE_WORDS);
            default: term_cnt = '0;
        endcase
    end

    tex_seg_counter #(
        .W(CNT_W)
    ) u_seg_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (accept),
        .term (term_cnt),
        .cnt  (cnt),
        .last (seg_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bird_wr  = 1'b0;
        pipe_wr  = 1'b0;
        base_wr  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = BIRD;
            end
            BIRD: begin
                bird_wr = accept;
                if (accept && seg_last) state_nx = PIPE;
            end
            PIPE: begin
                pipe_wr = accept;
                if (accept && seg_last) state_nx = BASE;
            end
            BASE: begin
                base_wr = accept;
                if (accept && seg_last) state_nx = DONE;
            end
            DONE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort cancels anything not yet registered, including a word offered this cycle.
        if (abort) begin
            state_nx = IDLE;
            bird_wr  = 1'b0;
            pipe_wr  = 1'b0;
            base_wr  = 1'b0;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bird_load_en   <= 1'b0;
            pipe_load_en   <= 1'b0;
            base_load_en   <= 1'b0;
            bird_load_addr <= '0;
            pipe_load_addr <= '0;
            base_load_addr <= '0;
            load_data      <= '0;
            done           <= 1'b0;
            loaded         <= 1'b0;
        end else begin
            bird_load_en <= bird_wr;
            pipe_load_en <= pipe_wr;
            base_load_en <= base_wr;
            if (bird_wr) bird_load_addr <= cnt[BIRD_AW-1:0];
            if (pipe_wr) pipe_load_addr <= cnt[PIPE_AW-1:0];
            if (base_wr) base_load_addr <= cnt[BASE_AW-1:0];
            if (bird_wr || pipe_wr || base_wr) load_data <= src_data;
            done <= done_nx;
            if (abort || start_ok) begin
                loaded <= 1'b0;
            end else if (done_nx) begin
                loaded <= 1'b1;
            end
        end
    end

    strobe_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({bird_load_en, pipe_load_en, base_load_en}));

endmodule

// File: tb/tb_sprite_tex_loader.sv
// Bench for sprite_tex_loader: flat-sequence reference model checked every cycle,
// plus literal checks on segment counts, boundaries, abort and async reset.
module tb_sprite_tex_loader;

    localparam int BW    = 5250;
    localparam int PW    = 40000;
    localparam int SW    = 9600;
    localparam int TOTAL = BW + PW + SW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        src_valid = 1'b0;
    logic [15:0] src_data = 16'h0;
    logic        src_ready;
    logic [15:0] load_data;
    logic        bird_load_en;
    logic [12:0] bird_load_addr;
    logic        pipe_load_en;
    logic [15:0] pipe_load_addr;
    logic        base_load_en;
    logic [13:0] base_load_addr;
    logic        busy;
    logic        done;
    logic        loaded;

    logic        rst_n_r = 1'b0;
    logic        start_r = 1'b0;
    logic        abort_r = 1'b0;
    logic        r_src_ready;
    logic [15:0] r_load_data;
    logic        r_bird_load_en;
    logic [12:0] r_bird_load_addr;
    logic        r_pipe_load_en;
    logic [15:0] r_pipe_load_addr;
    logic        r_base_load_en;
    logic [13:0] r_base_load_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_loaded;

    always #10 clk = ~clk;

    sprite_tex_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .load_data(load_data),
        .bird_load_en(bird_load_en), .bird_load_addr(bird_load_addr),
        .pipe_load_en(pipe_load_en), .pipe_load_addr(pipe_load_addr),
        .base_load_en(base_load_en), .base_load_addr(base_load_addr),
        .busy(busy), .done(done), .loaded(loaded)
    );

    // Short segments so the async-reset-in-BASE case is reached quickly.
    sprite_tex_loader #(.BIRD_WORDS(4), .PIPE_WORDS(5), .BASE_WORDS(6)) dut_r (
        .clk(clk), .rst_n(rst_n_r), .start(start_r), .abort(abort_r),
        .src_valid(src_valid), .src_data(src_data), .src_ready(r_src_ready),
        .load_data(r_load_data),
        .bird_load_en(r_bird_load_en), .bird_load_addr(r_bird_load_addr),
        .pipe_load_en(r_pipe_load_en), .pipe_load_addr(r_pipe_load_addr),
        .base_load_en(r_base_load_en), .base_load_addr(r_base_load_addr),
        .busy(r_busy), .done(r_done), .loaded(r_loaded)
    );

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int drv_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 3 + 'h1111);
    endfunction

    // Reference model: the load is one flat run of TOTAL words; position p maps to
    // a segment and a segment-relative address by plain subtraction.
    bit          m_run = 0;
    bit          m_donest = 0;
    bit          m_done = 0;
    bit          m_loaded = 0;
    int          m_pos = 0;
    int          m_seg = 0;
    logic [12:0] m_ab = '0;
    logic [15:0] m_ap = '0;
    logic [13:0] m_as = '0;
    logic [15:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin : model_p
        bit was_donest;
        if (!rst_n) begin
            m_run = 0; m_donest = 0; m_done = 0; m_loaded = 0; m_pos = 0; m_seg = 0;
            m_ab = '0; m_ap = '0; m_as = '0; m_data = '0;
        end else begin
            was_donest = m_donest;
            m_seg  = 0;
            m_done = 0;
            if (abort) begin
                m_run = 0; m_pos = 0; m_donest = 0; m_loaded = 0;
            end else begin
                if (was_donest) begin
                    m_done = 1; m_loaded = 1; m_donest = 0;
                end
                if (m_run && src_valid) begin
                    if (m_pos < BW) begin
                        m_seg = 1; m_ab = 13'(m_pos);
                    end else if (m_pos < BW + PW) begin
                        m_seg = 2; m_ap = 16'(m_pos - BW);
                    end else begin
                        m_seg = 3; m_as = 14'(m_pos - BW - PW);
                    end
                    m_data = pat(m_pos);
                    m_pos++;
                    if (m_pos == TOTAL) begin
                        m_run = 0; m_pos = 0; m_donest = 1;
                    end
                end else if (!m_run && !was_donest && start) begin
                    m_run = 1; m_pos = 0; m_loaded = 0;
                end
            end
        end
    end

    int n_cnt[3];
    int first_addr[3];
    int last_addr[3];
    int first_cyc[3];
    int last_cyc[3];
    int n_done = 0;
    int done_cyc = 0;

    task automatic mon_clear();
        for (int s = 0; s < 3; s++) begin
            n_cnt[s] = 0; first_addr[s] = -1; last_addr[s] = -1;
            first_cyc[s] = 0; last_cyc[s] = 0;
        end
        n_done = 0;
        done_cyc = 0;
    endtask

    task automatic monitor();
        logic [2:0] en;
        int a[3];
        en = {base_load_en, pipe_load_en, bird_load_en};
        a[0] = int'(bird_load_addr);
        a[1] = int'(pipe_load_addr);
        a[2] = int'(base_load_addr);
        for (int s = 0; s < 3; s++) begin
            if (en[s]) begin
                if (n_cnt[s] == 0) begin
                    first_addr[s] = a[s];
                    first_cyc[s] = cyc;
                end
                n_cnt[s]++;
                last_addr[s] = a[s];
                last_cyc[s] = cyc;
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cycle_compare();
        logic [65:0] exp_v;
        logic [65:0] act_v;
        exp_v = {m_run, m_run, m_done, m_loaded, (m_seg == 1), (m_seg == 2), (m_seg == 3),
                 m_ab, m_ap, m_as, m_data};
        act_v = {src_ready, busy, done, loaded, bird_load_en, pipe_load_en, base_load_en,
                 bird_load_addr, pipe_load_addr, base_load_addr, load_data};
        n_checks++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL cycle_model cyc=%0d got=%h expected=%h", cyc, act_v, exp_v);
            if (n_err >= 200) begin
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
                $finish;
            end
        end
    endtask

    // One cycle: check outputs mid-cycle, then drive the inputs for the next edge.
    task automatic step(input bit v, input bit st, input bit ab);
        @(negedge clk);
        if (rst_n) cycle_compare();
        monitor();
        start = st;
        abort = ab;
        src_valid = v;
        if (v) begin
            src_data = pat(drv_idx);
            if (src_ready && !ab) drv_idx++;
        end else begin
            src_data = 16'($urandom);
        end
    endtask

    initial begin : main_p
        int  guard;
        bit  found;

        mon_clear();
        repeat (3) @(negedge clk);
        check("reset_ctrl", int'({src_ready, busy, done, loaded,
                                  bird_load_en, pipe_load_en, base_load_en}), 0);
        check("reset_bird_addr", int'(bird_load_addr), 0);
        check("reset_pipe_addr", int'(pipe_load_addr), 0);
        check("reset_base_addr", int'(base_load_addr), 0);
        check("reset_load_data", int'(load_data), 0);
        rst_n = 1'b1;
        rst_n_r = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);

        // Random 30% valid near the start and around the bird/pipe boundary, abort after pipe 1234.
        mon_clear();
        drv_idx = 0;
        step(0, 1, 0);
        guard = 0;
        while (drv_idx < BW + 1235 && guard < 40000) begin
            if (drv_idx >= 400 && drv_idx < BW - 300) step(1, 0, 0);
            else step($urandom_range(0, 99) < 30, 0, 0);
            guard++;
        end
        check("rand_words_sent", drv_idx, BW + 1235);
        step(0, 0, 1);
        repeat (20) step(0, 0, 0);
        check("abort_bird_count", n_cnt[0], BW);
        check("abort_bird_last", last_addr[0], BW - 1);
        check("abort_pipe_first", first_addr[1], 0);
        check("abort_pipe_last", last_addr[1], 1234);
        check("abort_pipe_count", n_cnt[1], 1235);
        check("abort_no_base", n_cnt[2], 0);
        check("abort_no_done", n_done, 0);
        check("abort_idle", int'({busy, src_ready, loaded}), 0);

        // Restart from bird address 0, then cancel.
        mon_clear();
        drv_idx = 0;
        step(0, 1, 0);
        repeat (10) step(1, 0, 0);
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);
        check("restart_first_bird", first_addr[0], 0);
        check("restart_last_bird", last_addr[0], 9);
        check("restart_bird_count", n_cnt[0], 10);

        // start and abort together: abort wins.
        step(0, 1, 1);
        repeat (2) step(0, 0, 0);
        check("start_abort_idle", int'({busy, src_ready}), 0);

        // Full zero-stall load with a stray start during PIPE.
        mon_clear();
        drv_idx = 0;
        step(0, 1, 0);
        guard = 0;
        while (drv_idx < TOTAL && guard < TOTAL + 100) begin
            step(1, drv_idx == BW + 100, 0);
            guard++;
        end
        check("full_words_sent", drv_idx, TOTAL);
        guard = 0;
        while (n_done == 0 && guard < 10) begin
            step(0, 0, 0);
            guard++;
        end
        repeat (3) step(0, 0, 0);
        check("full_bird_count", n_cnt[0], 5250);
        check("full_pipe_count", n_cnt[1], 40000);
        check("full_base_count", n_cnt[2], 9600);
        check("full_bird_last", last_addr[0], 5249);
        check("full_pipe_first", first_addr[1], 0);
        check("full_pipe_last", last_addr[1], 39999);
        check("full_base_first", first_addr[2], 0);
        check("full_base_last", last_addr[2], 9599);
        check("bird_pipe_adjacent", first_cyc[1] - last_cyc[0], 1);
        check("pipe_base_adjacent", first_cyc[2] - last_cyc[1], 1);
        check("done_after_base", done_cyc - last_cyc[2], 1);
        check("done_pulses", n_done, 1);
        check("loaded_level", int'(loaded), 1);
        check("busy_after_done", int'(busy), 0);

        // Async reset while the short instance is writing its ground segment.
        step(0, 0, 0);
        start_r = 1'b1;
        step(0, 0, 0);
        start_r = 1'b0;
        found = 0;
        guard = 0;
        while (!found && guard < 40) begin
            step(1, 0, 0);
            guard++;
            found = r_base_load_en && (r_base_load_addr == 14'd2);
        end
        check("rst_reached_base", int'(found), 1);
        rst_n_r = 1'b0;
        #1;
        check("rst_mid_ctrl", int'({r_src_ready, r_busy, r_done, r_loaded,
                                    r_bird_load_en, r_pipe_load_en, r_base_load_en}), 0);
        check("rst_mid_bird_addr", int'(r_bird_load_addr), 0);
        check("rst_mid_pipe_addr", int'(r_pipe_load_addr), 0);
        check("rst_mid_base_addr", int'(r_base_load_addr), 0);
        check("rst_mid_load_data", int'(r_load_data), 0);
        step(0, 0, 0);
        rst_n_r = 1'b1;
        step(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_tex_loader.md
# sprite_tex_loader

Streams texture words from the SDRAM read path into the sprite renderer's three on-chip texture RAMs: bird, pipe, and ground base. One start pulse runs a fixed three-segment sequence. Each accepted source word becomes exactly one registered write strobe, with its address and data, on the renderer's load ports. The block sits between the SDRAM read FIFO and the renderer, in the 50 MHz load clock domain.

## Interface
Parameters:
- BIRD_WORDS, 5250: bird segment length (3 frames × 50×35).
- PIPE_WORDS, 40000: pipe segment length (80×500). All words are forwarded; the renderer itself discards addresses ≥ 4000.
- BASE_WORDS, 9600: ground segment length (64×150).

Ports:
- clk, in, 1: 50 MHz load clock; the single clock of the block.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle pulse that begins a load; ignored while busy.
- abort, in, 1: synchronous cancel; returns to IDLE.
- src_valid, in, 1: a source word is present.
- src_data, in, 16: RGB565 source word.
- src_ready, out, 1: block accepts a word this cycle.
- load_data, out, 16: shared write data for all three RAMs.
- bird_load_en, out, 1: bird RAM write strobe.
- bird_load_addr, out, 13: bird RAM address.
- pipe_load_en, out, 1: pipe RAM write strobe.
- pipe_load_addr, out, 16: pipe RAM address.
- base_load_en, out, 1: base RAM write strobe.
- base_load_addr, out, 14: base RAM address.
- busy, out, 1: high from the cycle after start until DONE.
- done, out, 1: one-cycle pulse after the last base write.
- loaded, out, 1: level; set with done, cleared by start or abort.

## Operation
- FSM states: IDLE, BIRD, PIPE, BASE, DONE.
- IDLE → BIRD on start. Word counter cnt is cleared to 0.
- A word is accepted on any edge where src_valid && src_ready.
- src_ready = 1 in BIRD, PIPE and BASE; 0 in IDLE and DONE. It is combinational from state only, with no dependence on src_valid.
- On each accepted word in state S:
  - the S-specific load_en pulses next cycle;
  - its load_addr = cnt, truncated to the port width;
  - load_data = src_data;
  - cnt increments.
- Segment end: when the word accepted has cnt == S_WORDS−1:
  - cnt is cleared;
  - BIRD → PIPE, PIPE → BASE, BASE → DONE.
- DONE: done = 1 for one cycle and loaded is set, then → IDLE.
- Only one load_en is high in any cycle.
- Address ports hold their last value when the strobe is low. load_data likewise holds.
- start while busy or in DONE is ignored.
- start and abort in the same cycle: abort wins.
- abort in any state:
  - next state IDLE, cnt = 0;
  - no further load_en strobes; a strobe already registered from the previous acceptance still issues;
  - done is not pulsed and loaded is cleared.
- src_valid gaps of any length stall the sequence without skipping or duplicating addresses.

## Timing
- Reset values: state IDLE, cnt 0, all *_load_en 0, all addresses 0, load_data 0, busy 0, done 0, loaded 0, src_ready 0.
- Latency: a word accepted at edge N produces load_en, addr and data valid between edges N and N+1. The renderer writes at edge N+1.
- Throughput: 1 word per cycle sustained.
- A full load with zero stalls takes 54850 accepting cycles. done rises exactly one cycle after the final base_load_en cycle.
- busy goes high the cycle after start and low in the cycle done is high.
- Segment boundaries add no bubble: the last bird word and the first pipe word may be accepted on consecutive edges.
- Asynchronous reset mid-load clears everything immediately. The renderer RAM contents are then partial; a fresh start is required.

## Structure
- The shared package holds:
  - segment lengths (5250, 40000, 9600);
  - the renderer RAM depths (5250, 4000, 9600);
  - the state encoding localparams;
  - address widths 13/16/14.
- The renderer imports the same RAM depth constants.
- One sub-module is natural: tex_seg_counter. It is a parameterised word counter with clear, increment and a last flag. Instantiate it once, with the terminal count muxed per state, or once per segment.
- Everything else is flat in sprite_tex_loader: the FSM, the output registers and the strobe decode.

## Test plan
- Reset, then start with src_valid held at 1 → 5250 bird strobes at addr 0..5249, then 40000 pipe strobes at 0..39999, then 9600 base strobes at 0..9599. done pulses once, exactly 1 cycle after the base write at 9599; loaded = 1.
- Random src_valid, 30% duty, and a scoreboard comparing src_data against a counting pattern → every RAM write receives the matching data at consecutive addresses. No address is repeated or skipped, including across the 5249→0 and 39999→0 segment transitions.
- Segment boundary with no stall → bird addr 5249 and pipe addr 0 strobes appear on adjacent cycles; bird_load_en and pipe_load_en are never high together.
- abort asserted after pipe addr 1234 is accepted → the strobe for addr 1234 still issues, then no strobes follow. State returns to IDLE, done = 0, loaded = 0. A new start restarts at bird addr 0.
- start pulsed during the PIPE segment, and start+abort in the same cycle → the first is ignored (the sequence continues unchanged); the second yields IDLE.
- rst_n driven low asynchronously mid-BASE → all outputs return to their reset values before the next clock edge, and src_ready = 0.
